// File: rtl/beat_sequencer_if.sv
// Control pulses into and tempo/step outputs out of the beat sequencer.
// master drives the KEY pulses and observes the outputs; slave is the sequencer itself.
interface beat_sequencer_if #(
    parameter int NUM_STEPS = 8
);
    logic                         play_toggle;
    logic                         rewind;
    logic                         bpm_up;
    logic                         bpm_down;
    logic [$clog2(NUM_STEPS)-1:0] beat;
    logic                         step_tick;
    logic                         running;
    logic [7:0]                   bpm;

    modport master (
        output play_toggle, rewind, bpm_up, bpm_down,
        input  beat, step_tick, running, bpm
    );

    modport slave (
        input  play_toggle, rewind, bpm_up, bpm_down,
        output beat, step_tick, running, bpm
    );
endinterface

// File: rtl/beat_sequencer.sv
// Tempo engine producing the step index for the LED display and drum voices.
// A phase accumulator (no divider) advances the beat at bpm*STEPS_PER_BEAT steps per minute.
module beat_sequencer #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int NUM_STEPS      = 8,
    parameter int STEPS_PER_BEAT = 2,
    parameter int BPM_DEFAULT    = 120,
    parameter int BPM_MIN        = 60,
    parameter int BPM_MAX        = 240,
    parameter int BPM_STEP       = 4
) (
    input logic              clk,
    input logic              reset_n,
    beat_sequencer_if.slave  bus
);

    localparam int          BEAT_W     = $clog2(NUM_STEPS);
    localparam longint      LIMIT_WIDE = longint'(CLK_HZ) * longint'(60);
    localparam logic [32:0] LIMIT      = 33'(LIMIT_WIDE);

    localparam logic [0:0] STOPPED = 1'b0;
    localparam logic [0:0] RUNNING = 1'b1;

    logic [0:0]        state;
    logic [31:0]       acc;
    logic [BEAT_W-1:0] beat;
    logic              step_tick;
    logic              running;
    logic [7:0]        bpm;

    logic [15:0]       inc;
    logic [32:0]       sum;
    logic [32:0]       sum_wrapped;
    logic              wrap;
    logic [BEAT_W-1:0] beat_next;
    logic [8:0]        bpm_up_val;
    logic [7:0]        bpm_next;

    // Accumulator sum is kept one bit wider so LIMIT near 2^32 cannot alias.
    always_comb begin
        inc         = 16'(bpm) * 16'(STEPS_PER_BEAT);
        sum         = {1'b0, acc} + {17'd0, inc};
        wrap        = (sum >= LIMIT);
        sum_wrapped = sum - LIMIT;
        beat_next   = (beat == BEAT_W'(NUM_STEPS - 1)) ? '0 : beat + 1'b1;
    end

    always_comb begin
        bpm_up_val = {1'b0, bpm} + 9'(BPM_STEP);
        bpm_next   = bpm;
        if (bus.bpm_up && !bus.bpm_down) begin
            bpm_next = (bpm_up_val > 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpm_up_val[7:0];
        end else if (bus.bpm_down && !bus.bpm_up) begin
            bpm_next = ({1'b0, bpm} < 9'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN) : bpm - 8'(BPM_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STOPPED;
            acc       <= '0;
            beat      <= '0;
            step_tick <= 1'b0;
            running   <= 1'b0;
            bpm       <= 8'(BPM_DEFAULT);
        end else begin
            step_tick <= 1'b0;
            bpm       <= bpm_next;
            case (state)
                STOPPED: begin
                    // Starting re-sounds the step already on display.
                    if (bus.play_toggle) begin
                        state     <= RUNNING;
                        running   <= 1'b1;
                        acc       <= '0;
                        step_tick <= 1'b1;
                        if (bus.rewind) begin
                            beat <= '0;
                        end
                    end else if (bus.rewind) begin
                        beat <= '0;
                        acc  <= '0;
                    end
                end
                RUNNING: begin
                    if (bus.play_toggle) begin
                        state   <= STOPPED;
                        running <= 1'b0;
                        if (bus.rewind) begin
                            beat <= '0;
                            acc  <= '0;
                        end
                    end else if (bus.rewind) begin
                        beat      <= '0;
                        acc       <= '0;
                        step_tick <= 1'b1;
                    end else if (wrap) begin
                        acc       <= sum_wrapped[31:0];
                        beat      <= beat_next;
                        step_tick <= 1'b1;
                    end else begin
                        acc <= sum[31:0];
                    end
                end
                default: begin
                    state   <= STOPPED;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.beat      = beat;
    assign bus.step_tick = step_tick;
    assign bus.running   = running;
    assign bus.bpm       = bpm;

endmodule
